// File: rtl/enemy_pkg.sv
//------------------------------------------------------------------------------
// Module : enemy_pkg
// Brief  : Shared state encoding and defaults for the enemy fire scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package enemy_pkg;

  localparam int NUM_COLS = 8;

  typedef logic [4:0] state_t;

  // One-hot encoding; any other code is illegal and recovers to IDLE.
  localparam state_t ST_IDLE     = 5'b00001;
  localparam state_t ST_COOLDOWN = 5'b00010;
  localparam state_t ST_SELECT   = 5'b00100;
  localparam state_t ST_FIRE     = 5'b01000;
  localparam state_t ST_HALTED   = 5'b10000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
//------------------------------------------------------------------------------
// Module : rr_picker
// Brief  : Combinational round-robin search starting just after i_last.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_grant_idx,
  output logic         o_found
);

  logic [W-1:0] w_idx;

  // Scan farthest-first so the nearest candidate after i_last wins.
  always_comb begin
    o_grant_idx = '0;
    o_found     = 1'b0;
    w_idx       = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = W'((int'(i_last) + k) % N);
      if (i_req[w_idx]) begin
        o_grant_idx = w_idx;
        o_found     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
//------------------------------------------------------------------------------
// Module : enemy_fire_scheduler
// Brief  : Cooldown-paced round-robin selection of the enemy column that fires.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enemy_fire_scheduler
  import enemy_pkg::*;
#(
  parameter int          num_cols_p   = NUM_COLS,
  parameter logic [15:0] fire_delay_p = 16'd60
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          frame_i,
  input  logic                          start_i,
  input  logic [num_cols_p-1:0]         col_ready_i,
  input  logic                          bullet_busy_i,
  input  logic                          fire_ready_i,
  output logic                          fire_valid_o,
  output logic [$clog2(num_cols_p)-1:0] fire_col_o,
  output logic                          all_dead_o,
  output logic [7:0]                    shots_o
);

  localparam int CW = $clog2(num_cols_p);

  state_t        r_state;
  logic [15:0]   r_delay;
  logic [CW-1:0] r_last_grant;
  logic [CW-1:0] r_fire_col;
  logic [7:0]    r_shots;

  logic [CW-1:0] w_grant;
  logic          w_found;

  rr_picker #(
    .N (num_cols_p),
    .W (CW)
  ) u_picker (
    .i_req       (col_ready_i),
    .i_last      (r_last_grant),
    .o_grant_idx (w_grant),
    .o_found     (w_found)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_delay      <= 16'd0;
      r_last_grant <= CW'(num_cols_p - 1);
      r_fire_col   <= '0;
      r_shots      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_delay <= fire_delay_p;
            r_state <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (r_delay == 16'd0) begin
            if (!bullet_busy_i) r_state <= ST_SELECT;
          end else if (frame_i) begin
            r_delay <= r_delay - 16'd1;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_fire_col <= w_grant;
            r_state    <= ST_FIRE;
          end else begin
            r_state <= ST_HALTED;
          end
        end
        ST_FIRE: begin
          // An accepted handshake takes precedence over a column dropping out.
          if (fire_ready_i) begin
            r_last_grant <= r_fire_col;
            r_delay      <= fire_delay_p;
            r_shots      <= sat_inc8(r_shots);
            r_state      <= ST_COOLDOWN;
          end else if (!col_ready_i[r_fire_col]) begin
            r_state <= ST_SELECT;
          end
        end
        ST_HALTED: begin
          if (start_i && (|col_ready_i)) begin
            r_delay <= fire_delay_p;
            r_state <= ST_COOLDOWN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fire_valid_o = (r_state == ST_FIRE);
  assign fire_col_o   = r_fire_col;
  assign all_dead_o   = (r_state == ST_HALTED);
  assign shots_o      = r_shots;

endmodule

`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_enemy_fire_scheduler
// Brief  : Directed self-checking bench for enemy_fire_scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_enemy_fire_scheduler;

  logic       clk = 1'b0;
  logic       reset, frame, start, busy, fire_ready;
  logic [7:0] col_ready;

  logic       fire_valid, all_dead;
  logic [2:0] fire_col;
  logic [7:0] shots;

  logic       z_fire_valid, z_all_dead;
  logic [2:0] z_fire_col;
  logic [7:0] z_shots;

  int n_checks = 0;
  int n_errors = 0;
  int exp_shots = 0;
  int n;

  always #5 clk = ~clk;

  enemy_fire_scheduler #(
    .num_cols_p   (8),
    .fire_delay_p (16'd3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .frame_i       (frame),
    .start_i       (start),
    .col_ready_i   (col_ready),
    .bullet_busy_i (busy),
    .fire_ready_i  (fire_ready),
    .fire_valid_o  (fire_valid),
    .fire_col_o    (fire_col),
    .all_dead_o    (all_dead),
    .shots_o       (shots)
  );

  enemy_fire_scheduler #(
    .num_cols_p   (8),
    .fire_delay_p (16'd0)
  ) dut_zero (
    .clk_i         (clk),
    .reset_i       (reset),
    .frame_i       (frame),
    .start_i       (start),
    .col_ready_i   (col_ready),
    .bullet_busy_i (busy),
    .fire_ready_i  (fire_ready),
    .fire_valid_o  (z_fire_valid),
    .fire_col_o    (z_fire_col),
    .all_dead_o    (z_all_dead),
    .shots_o       (z_shots)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (!fire_valid && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_dead(input int limit, output int cnt);
    cnt = 0;
    while (!all_dead && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  // One accepted handshake: shot counter advances, request drops.
  task automatic accept_shot(input string tag);
    tick();
    if (exp_shots < 255) exp_shots++;
    check({tag, "_shots"}, 32'(shots), 32'(exp_shots));
    check({tag, "_valid_after"}, 32'(fire_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; frame = 1'b1; start = 1'b0; busy = 1'b0;
    fire_ready = 1'b1; col_ready = 8'hFF;
    tick(); tick();
    check("rst_valid", 32'(fire_valid), 32'd0);
    check("rst_col",   32'(fire_col),   32'd0);
    check("rst_dead",  32'(all_dead),   32'd0);
    check("rst_shots", 32'(shots),      32'd0);
    reset = 1'b0;

    // Full rotation with all columns ready
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("zero_delay_select", 32'(z_fire_valid), 32'd0);
    tick();
    check("zero_delay_fire", 32'(z_fire_valid), 32'd1);
    check("zero_delay_col",  32'(z_fire_col),   32'd0);
    wait_valid(20, n);
    check("rot_lat0", 32'(n), 32'd3);
    check("rot_col0", 32'(fire_col), 32'd0);
    accept_shot("rot0");
    for (int g = 1; g < 9; g++) begin
      wait_valid(20, n);
      check("rot_lat", 32'(n), 32'd5);
      check("rot_col", 32'(fire_col), 32'(g % 8));
      accept_shot("rot");
    end

    // Two sparse columns alternate
    col_ready = 8'b0010_0100;
    for (int g = 0; g < 4; g++) begin
      wait_valid(20, n);
      check("alt_lat", 32'(n), 32'd5);
      check("alt_col", 32'(fire_col), (g % 2 == 0) ? 32'd2 : 32'd5);
      accept_shot("alt");
    end

    // Bullet in flight blocks selection after the delay expires
    busy = 1'b1;
    n = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (fire_valid) n++;
    end
    check("busy_no_fire", 32'(n), 32'd0);
    busy = 1'b0;
    tick();
    check("busy_select", 32'(fire_valid), 32'd0);
    tick();
    check("busy_fire", 32'(fire_valid), 32'd1);
    check("busy_col",  32'(fire_col),   32'd2);
    accept_shot("busy");

    // Column withdrawal while waiting, then drop racing an accept
    fire_ready = 1'b0;
    col_ready  = 8'b1011_0000;
    wait_valid(20, n);
    check("wd_col4", 32'(fire_col), 32'd4);
    col_ready = 8'b1010_0000;
    tick();
    check("wd_drop_valid", 32'(fire_valid), 32'd0);
    tick();
    check("wd_regrant_valid", 32'(fire_valid), 32'd1);
    check("wd_regrant_col",   32'(fire_col),   32'd5);
    col_ready  = 8'b1000_0000;
    fire_ready = 1'b1;
    accept_shot("race");
    wait_valid(20, n);
    check("race_next_col", 32'(fire_col), 32'd7);
    accept_shot("race_next");

    // No live columns halts; restart with one column
    col_ready = 8'h00;
    wait_dead(20, n);
    check("halt_dead",  32'(all_dead),   32'd1);
    check("halt_valid", 32'(fire_valid), 32'd0);
    check("halt_lat",   32'(n),          32'd5);
    start = 1'b1; col_ready = 8'h01;
    tick();
    start = 1'b0;
    check("restart_dead", 32'(all_dead), 32'd0);
    fire_ready = 1'b0;
    wait_valid(20, n);
    check("restart_lat", 32'(n),        32'd5);
    check("restart_col", 32'(fire_col), 32'd0);
    tick(); tick();
    check("hold_valid", 32'(fire_valid), 32'd1);
    check("hold_col",   32'(fire_col),   32'd0);

    // Reset during FIRE drops the request
    reset = 1'b1;
    tick();
    check("rstfire_valid", 32'(fire_valid), 32'd0);
    check("rstfire_col",   32'(fire_col),   32'd0);
    check("rstfire_dead",  32'(all_dead),   32'd0);
    check("rstfire_shots", 32'(shots),      32'd0);
    reset = 1'b0;
    exp_shots = 0;

    // Shot counter saturation
    col_ready = 8'hFF; fire_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_valid(20, n);
      check("sat_lat", 32'(n), 32'd5);
      tick();
      if (i == 254) check("sat_255", 32'(shots), 32'd255);
    end
    check("sat_hold", 32'(shots), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 The block SHALL have parameter num_cols_p, default 8, meaning the number of enemy columns competing to fire.
REQ-002 The block SHALL have parameter fire_delay_p, default 16'd60, meaning the cooldown in frames between accepted shots.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock.
REQ-004 The block SHALL have port reset_i, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port frame_i, input, 1, a one-cycle pulse per processed frame.
REQ-006 The block SHALL have port start_i, input, 1, the btnC start request.
REQ-007 The block SHALL have port col_ready_i, input, num_cols_p, where bit n=1 means column n has a live bottom ship able to fire.
REQ-008 The block SHALL have port bullet_busy_i, input, 1, meaning an enemy bullet is in flight.
REQ-009 The block SHALL have port fire_ready_i, input, 1, meaning the bullet unit accepts a fire request.
REQ-010 The block SHALL have port fire_valid_o, output, 1, the fire request.
REQ-011 The block SHALL have port fire_col_o, output, $clog2(num_cols_p), the selected column.
REQ-012 The block SHALL have port all_dead_o, output, 1, meaning no column was able to fire.
REQ-013 The block SHALL have port shots_o, output, 8, the count of accepted shots.

Function
REQ-014 The FSM SHALL have the one-hot states IDLE, COOLDOWN, SELECT, FIRE and HALTED.
REQ-015 In IDLE, start_i=1 SHALL load the delay counter with fire_delay_p and go to COOLDOWN; otherwise the FSM stays in IDLE.
REQ-016 In COOLDOWN, the delay counter SHALL decrement by 1 on each frame_i while it is nonzero, and SHALL never wrap below 0.
REQ-017 In COOLDOWN, when delay==0 and bullet_busy_i=0, the FSM SHALL go to SELECT on the next edge; while busy it stays in COOLDOWN with delay held at 0.
REQ-018 SELECT SHALL last one cycle and perform a round-robin search of col_ready_i beginning at (last_grant+1) mod num_cols_p and wrapping.
REQ-019 If SELECT finds a set bit, the block SHALL latch that index into fire_col and go to FIRE.
REQ-020 If SELECT finds no set bit, the block SHALL go to HALTED.
REQ-021 In FIRE, fire_valid_o SHALL be 1 and fire_col_o SHALL be held stable until the handshake completes or the request is withdrawn.
REQ-022 In FIRE with fire_ready_i=1, the block SHALL set last_grant=fire_col, reload delay with fire_delay_p, increment shots_o (saturating at 255) and go to COOLDOWN.
REQ-023 In FIRE with fire_ready_i=0 and col_ready_i[fire_col]=0, the request SHALL be withdrawn and the FSM SHALL go to SELECT; if fire_ready_i and the column drop occur in the same cycle, fire_ready_i wins.
REQ-024 fire_delay_p=0 SHALL cause SELECT on the first non-busy cycle after COOLDOWN is entered.
REQ-025 In HALTED, all_dead_o SHALL be 1.
REQ-026 In HALTED, start_i=1 with any col_ready_i bit set SHALL reload the delay counter, clear all_dead_o and go to COOLDOWN.
REQ-027 The FSM SHALL treat any illegal state code as IDLE on the next edge.
REQ-028 fire_valid_o SHALL be a registered-state decode, with zero combinational path from fire_ready_i.

Reset
REQ-029 reset_i SHALL force the state to IDLE, delay=0, last_grant=num_cols_p-1 (so the first search starts at column 0), fire_col=0 and shots=0.
REQ-030 Reset outputs SHALL be fire_valid_o=0, fire_col_o=0, all_dead_o=0 and shots_o=0.
REQ-031 reset_i SHALL take priority over every other input, including when asserted during FIRE, and SHALL drop any pending request without a handshake.

Structure
REQ-032 The state enum and the default NUM_COLS=8 SHALL live in a shared package, enemy_pkg.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req, last; outputs grant_idx, found).
REQ-034 The delay counter and shots counter SHALL be inline registers.

Verification
REQ-035 Scenario: reset, start_i, fire_delay_p=3, col_ready_i=8'b1111_1111, fire_ready_i held high -> first fire_col_o=0 after 3 frames, then 1, 2, ... 7, 0; shots_o increments once per grant.
REQ-036 Scenario: col_ready_i=8'b0010_0100, last_grant=2 -> grant 5, then 2, alternating.
REQ-037 Scenario: bullet_busy_i=1 when delay reaches 0 for 10 cycles -> fire_valid_o stays 0 and SELECT occurs one cycle after busy drops.
REQ-038 Scenario: in FIRE col=4, fire_ready_i=0, col_ready_i[4] drops -> fire_valid_o drops, and the next grant is the next set bit above 4; the same drop with fire_ready_i=1 -> accepted, shots_o+1.
REQ-039 Scenario: col_ready_i=0 at SELECT -> HALTED, all_dead_o=1; start_i with col_ready_i=8'h01 -> COOLDOWN, all_dead_o=0.
REQ-040 Scenario: reset_i during FIRE -> the next cycle shows all outputs 0; 256 accepted shots -> shots_o=255.
